div_iter: RTL and testbench
===========================

// Module: div_iter
// PURPOSE
//  Iterative radix-2 restoring divider, stage directly downstream of the
//  operand-magnitude stage. Consumes unsigned magnitudes N (dividend) and D
//  (divisor) plus quotient sign signo; produces signed quotient Q and
//  unsigned remainder magnitude R. One quotient bit per clock;
//  start/busy/done handshake.
// PARAMETERS
//  WIDTH  32  operand/result width in bits; count register is $clog2(WIDTH)+1 bits
// PORTS
//  clk    in   1      clock, all state updates on rising edge
//  rst    in   1      synchronous reset, active-high
//  start  in   1      request; sampled only in IDLE
//  N      in   WIDTH  dividend magnitude (unsigned)
//  D      in   WIDTH  divisor magnitude (unsigned)
//  signo  in   1      1 = negate quotient
//  busy   out  1      1 in RUN and FIX
//  done   out  1      one-cycle pulse: Q/R/dbz valid
//  Q      out  WIDTH  quotient, two's complement when signo=1
//  R      out  WIDTH  remainder magnitude (unsigned, never negated)
//  dbz    out  1      divide-by-zero flag for the last operation
// BEHAVIOUR
//  Reset: state=IDLE; busy=0, done=0, Q=0, R=0, dbz=0; internal regs cleared.
//   Reset has priority in every state, including mid-RUN; the operation is dropped.
//  FSM states: IDLE -> RUN -> FIX -> DONE -> IDLE.
//   IDLE: if start and D!=0: latch N, D, signo; rem=0; cnt=0 -> RUN.
//         If start and D==0: Q=all-ones, R=N, dbz=1 -> DONE. No sign applied.
//         If start=0: stay in IDLE.
//   RUN: per edge: t={rem,quo[MSB]}; quo<<=1;
//        if t>=D then rem=t-D and quo[0]=1, else rem=t.
//        Compare and subtract use WIDTH+1 bits, so D>2^(WIDTH-1) does not overflow.
//        After WIDTH iterations -> FIX.
//   FIX:  Q = signo ? (~quo+1) : quo, truncated to WIDTH (wraps);
//         R = rem; dbz=0 -> DONE.
//   DONE: done=1 for this cycle only -> IDLE.
//  Latency: start sampled at edge k, D!=0 -> done=1 in the cycle after edge k+WIDTH+1
//   (k+33 for WIDTH=32). D==0 -> done=1 in the cycle after edge k.
//  Q, R and dbz hold their values until the next DONE entry or reset.
//   They are not cleared on a new start.
//  start while busy or done=1: ignored, with no queuing.
//   The operands of an ignored start are not latched.
//  N, D and signo may change after the start edge without affecting the result.
//  Boundaries:
//   N=0 -> Q=0, R=0; signo=1 still yields Q=0.
//   N<D -> Q=0, R=N.
//   D=1 -> Q=N (negated if signo), R=0.
// TESTING
//  T1: N=C, D=4, signo=0, start 1 cycle -> done after 33 edges; Q=3, R=0, dbz=0.
//  T2: N=F, D=6, signo=0 -> Q=2, R=3.
//      Same operands with signo=1 -> Q=FFFFFFFE, R=3.
//  T3: N=5, D=0, start -> done in the next cycle; Q=FFFFFFFF, R=5, dbz=1, busy never 1.
//  T4: N=FFFFFFFF, D=1 -> Q=FFFFFFFF, R=0.
//      N=FFFFFFFF, D=80000001 -> Q=1, R=7FFFFFFE.
//  T5: start N=64, D=A; pulse start again with N=1, D=1 at edge 10 -> ignored.
//      Result Q=A, R=0; exactly one done pulse.
//  T6: rst=1 at edge 15 of RUN -> busy=0, done=0, Q=0, R=0 next cycle.
//      A new start N=9, D=2 then completes with Q=4, R=1.

Source files
------------

// File: rtl/div_iter.sv
// -----------------------------------------------------------------------------
// div_iter - iterative radix-2 restoring divider
//
// Takes unsigned magnitudes from the operand-magnitude stage and produces a
// signed quotient plus an unsigned remainder magnitude, one quotient bit per
// clock.
//
// Ports
//   clk        clock, every state update on the rising edge
//   rst        synchronous reset, active-high, wins in every state
//   start      operation request, only looked at while idle
//   N          dividend magnitude (unsigned)
//   D          divisor magnitude (unsigned)
//   signo      1 = return the quotient negated (two's complement)
//   busy       1 while iterating or fixing up the sign (RUN, FIX)
//   done       one-cycle pulse, Q/R/dbz are valid for the new result
//   Q          quotient, two's complement when signo was 1
//   R          remainder magnitude, never negated
//   dbz        divide-by-zero flag of the last completed operation
//   state_dbg  current FSM state (0 IDLE, 1 RUN, 2 FIX, 3 DONE)
//
// Handshake: a request is accepted only on a rising edge where the FSM is in
// IDLE and start=1; the operands are captured on that same edge. A start seen
// while busy or done is high is dropped, not queued, and its operands are
// never captured. done is high for exactly the one cycle spent in DONE, and
// Q/R/dbz then hold until the next completion or reset.
// -----------------------------------------------------------------------------
module div_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] N,
  input  logic [WIDTH-1:0] D,
  input  logic             signo,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] R,
  output logic             dbz,
  output logic [1:0]       state_dbg
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0]    CNT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0]    CNT_ONE  = CW'(1);
  localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t state;
  state_t state_nxt;

  // Working registers of the iteration.
  logic [WIDTH-1:0] quo;   // dividend bits shift out the top, quotient bits in the bottom
  logic [WIDTH-1:0] rem;   // partial remainder, always < dvs
  logic [WIDTH-1:0] dvs;   // captured divisor
  logic             sgn;   // captured quotient sign
  logic [CW-1:0]    cnt;   // iterations already performed

  // Per-iteration datapath.
  logic [WIDTH:0]   trial;
  logic             fits;
  logic [WIDTH-1:0] rem_sub;
  logic             last_iter;
  logic             req_ok;
  logic             req_dbz;

  // The trial value needs WIDTH+1 bits: with a divisor above 2^(WIDTH-1)
  // the shifted remainder can exceed WIDTH bits before the subtraction.
  assign trial = {rem, quo[WIDTH-1]};
  assign fits  = (trial >= {1'b0, dvs});
  // When fits is true the true difference is below dvs, so it is exactly
  // the low WIDTH bits of the modular subtraction.
  assign rem_sub   = trial[WIDTH-1:0] - dvs;
  assign last_iter = (cnt == CNT_LAST);

  assign req_ok  = (state == S_IDLE) && start && (D != '0);
  assign req_dbz = (state == S_IDLE) && start && (D == '0);

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (req_ok) begin
          state_nxt = S_RUN;
        end else if (req_dbz) begin
          // Nothing to iterate: the result is known on the accepting edge.
          state_nxt = S_DONE;
        end
      end
      S_RUN: begin
        if (last_iter) begin
          state_nxt = S_FIX;
        end
      end
      S_FIX:   state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    busy      = 1'b0;
    done      = 1'b0;
    state_dbg = state;
    case (state)
      S_RUN:   busy = 1'b1;
      S_FIX:   busy = 1'b1;
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      quo <= '0;
      rem <= '0;
      dvs <= '0;
      sgn <= 1'b0;
      cnt <= '0;
      Q   <= '0;
      R   <= '0;
      dbz <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_ok) begin
            quo <= N;
            dvs <= D;
            sgn <= signo;
            rem <= '0;
            cnt <= '0;
          end else if (req_dbz) begin
            // Divide by zero: fixed all-ones quotient, dividend as remainder,
            // deliberately without applying the sign.
            Q   <= '1;
            R   <= N;
            dbz <= 1'b1;
          end
        end
        S_RUN: begin
          quo <= {quo[WIDTH-2:0], fits};
          rem <= fits ? rem_sub : trial[WIDTH-1:0];
          cnt <= cnt + CNT_ONE;
        end
        S_FIX: begin
          // Negation wraps modulo 2^WIDTH, so a zero quotient stays zero.
          Q   <= sgn ? (~quo + ONE) : quo;
          R   <= rem;
          dbz <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Local properties
  // ---------------------------------------------------------------------------
  a_done_single : assert property (@(posedge clk) disable iff (rst) done |=> !done);
  a_busy_done_excl : assert property (@(posedge clk) disable iff (rst) !(busy && done));
  a_run_count : assert property (@(posedge clk) disable iff (rst)
                                 (state == S_RUN) |-> (cnt <= CNT_LAST));

endmodule

// File: tb/tb_div_iter.sv
// -----------------------------------------------------------------------------
// tb_div_iter - self-checking bench for div_iter (WIDTH = 32)
//
// Every accepted request pushes its reference result and expected latency;
// a negedge monitor pops and compares whenever done is seen.
// -----------------------------------------------------------------------------
module tb_div_iter;

  localparam int W = 32;
  localparam int RES_W = 2 * W + 1;   // {dbz, R, Q}

  logic         clk;
  logic         rst;
  logic         start;
  logic [W-1:0] N;
  logic [W-1:0] D;
  logic         signo;
  logic         busy;
  logic         done;
  logic [W-1:0] Q;
  logic [W-1:0] R;
  logic         dbz;
  logic [1:0]   state_dbg;

  div_iter #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .N         (N),
    .D         (D),
    .signo     (signo),
    .busy      (busy),
    .done      (done),
    .Q         (Q),
    .R         (R),
    .dbz       (dbz),
    .state_dbg (state_dbg)
  );

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;   // number of the most recent rising edge
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL global_timeout bench did not finish");
    $fatal(1, "global timeout");
  end

  // ---------------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------------
  logic [RES_W-1:0] exp_q[$];
  int               lat_q[$];
  int               edge_q[$];
  int               errors = 0;
  int               checks = 0;
  int               done_cnt = 0;

  task automatic check(input string tag, input logic [RES_W-1:0] got,
                       input logic [RES_W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [RES_W-1:0] model(input logic [W-1:0] n,
                                             input logic [W-1:0] d,
                                             input logic s);
    logic [W-1:0] q;
    logic [W-1:0] r;
    if (d == '0) return {1'b1, n, {W{1'b1}}};
    q = n / d;
    r = n % d;
    if (s) q = -q;
    return {1'b0, r, q};
  endfunction

  always @(negedge clk) begin
    if (!rst && done) begin
      done_cnt++;
      if (exp_q.size() == 0) begin
        check("spurious_done", 1, 0);
      end else begin
        logic [RES_W-1:0] e;
        int               l;
        int               k;
        e = exp_q.pop_front();
        l = lat_q.pop_front();
        k = edge_q.pop_front();
        check("result", {dbz, R, Q}, e);
        check("latency", RES_W'(cyc - k), RES_W'(l));
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Driver tasks (all called at a falling edge)
  // ---------------------------------------------------------------------------
  task automatic wait_idle();
    int n = 0;
    while ((busy || done) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) check("idle_timeout", 1, 0);
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      check("drain_timeout", RES_W'(exp_q.size()), 0);
      exp_q.delete();
      lat_q.delete();
      edge_q.delete();
    end
  endtask

  // Issue one request; returns at the falling edge after the accepting edge,
  // with the operand inputs scrambled to show they are no longer looked at.
  task automatic do_op(input logic [W-1:0] n, input logic [W-1:0] d, input logic s);
    wait_idle();
    start = 1'b1;
    N     = n;
    D     = d;
    signo = s;
    exp_q.push_back(model(n, d, s));
    lat_q.push_back((d == '0) ? 0 : W + 1);
    edge_q.push_back(cyc + 1);
    @(negedge clk);
    start = 1'b0;
    N     = $urandom;
    D     = $urandom;
    signo = 1'($urandom_range(0, 1));
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    int k;
    int dc;
    rst   = 1'b1;
    start = 1'b0;
    N     = '0;
    D     = '0;
    signo = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", RES_W'(busy), 0);
    check("rst_done", RES_W'(done), 0);
    check("rst_Q", RES_W'(Q), 0);
    check("rst_R", RES_W'(R), 0);
    check("rst_dbz", RES_W'(dbz), 0);
    check("rst_state", RES_W'(state_dbg), 0);
    rst = 1'b0;
    @(negedge clk);

    // T1
    do_op(32'hC, 32'h4, 1'b0);
    check("t1_busy", RES_W'(busy), 1);
    wait_drain();
    repeat (5) @(negedge clk);
    check("t1_hold_Q", RES_W'(Q), 3);

    // T2: previous result must survive a new start
    do_op(32'hF, 32'h6, 1'b0);
    check("t2_q_not_cleared", RES_W'(Q), 3);
    do_op(32'hF, 32'h6, 1'b1);
    wait_drain();

    // T3: divide by zero, never busy
    do_op(32'h5, 32'h0, 1'b0);
    check("t3_busy0", RES_W'(busy), 0);
    @(negedge clk);
    check("t3_busy1", RES_W'(busy), 0);
    wait_drain();

    // T4 and boundaries
    do_op(32'hFFFF_FFFF, 32'h1, 1'b0);
    do_op(32'hFFFF_FFFF, 32'h8000_0001, 1'b0);
    do_op(32'h0, 32'h7, 1'b1);
    do_op(32'h3, 32'h9, 1'b0);
    do_op(32'h1234_5678, 32'h1, 1'b1);
    do_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    do_op(32'h0, 32'h0, 1'b1);
    wait_drain();

    // T5: start during RUN is ignored
    dc = done_cnt;
    do_op(32'h64, 32'hA, 1'b0);
    k = cyc;
    while (cyc < k + 9) @(negedge clk);
    start = 1'b1;
    N     = 32'h1;
    D     = 32'h1;
    @(negedge clk);
    start = 1'b0;
    wait_drain();
    repeat (40) @(negedge clk);
    check("t5_one_done", RES_W'(done_cnt - dc), 1);
    check("t5_Q", RES_W'(Q), 32'hA);

    // T6: reset mid-RUN drops the operation
    do_op(32'h1234, 32'h7, 1'b0);
    k = cyc;
    while (cyc < k + 14) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("t6_busy", RES_W'(busy), 0);
    check("t6_done", RES_W'(done), 0);
    check("t6_Q", RES_W'(Q), 0);
    check("t6_R", RES_W'(R), 0);
    exp_q.delete();
    lat_q.delete();
    edge_q.delete();
    rst = 1'b0;
    @(negedge clk);
    do_op(32'h9, 32'h2, 1'b0);
    wait_drain();

    // Random operations
    for (int i = 0; i < 24; i++) begin
      logic [W-1:0] n;
      logic [W-1:0] d;
      n = $urandom;
      case ($urandom_range(0, 3))
        0:       d = $urandom_range(1, 255);
        1:       d = $urandom;
        2:       d = n >> $urandom_range(0, 31);
        default: d = (i % 8 == 0) ? '0 : W'($urandom_range(1, 65535));
      endcase
      do_op(n, d, 1'($urandom_range(0, 1)));
    end
    wait_drain();
    repeat (3) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
